mul_share_sched: RTL and testbench
==================================

MUL_SHARE_SCHED -- requirements
Module: mul_share_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of requesters (range 2..4).
REQ-002 The block SHALL have parameter LAT, default 3, giving the number of enabled clock edges from operand capture to result valid. It SHALL be fixed at 3.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operand valid.
REQ-006 req_ready  output  NREQ  per-requester operand accept, one-hot or zero.
REQ-007 req_a  input  NREQ*16  signed multiplicands; slice i belongs to requester i.
REQ-008 req_b  input  NREQ*8  unsigned multipliers; slice i belongs to requester i.
REQ-009 rsp_valid  output  NREQ  per-requester result valid, one-hot or zero.
REQ-010 rsp_ready  input  NREQ  per-requester result accept.
REQ-011 rsp_p  output  25  signed product, shared by all requesters and qualified by rsp_valid.
REQ-012 busy  output  1  high while any operation is in flight.

Function
REQ-013 An accept SHALL occur for requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-014 At most one requester SHALL be granted per cycle. Arbitration SHALL be round-robin, searching from (last_grant+1) mod NREQ upward.
REQ-015 last_grant SHALL update only on an accept.
REQ-016 The granted requester's a and b SHALL be muxed onto the multiplier inputs combinationally in the same cycle.
REQ-017 The multiplier ce SHALL be driven by ce = NOT stall.
REQ-018 stall SHALL be defined as: tag_v[LAT-1] high AND rsp_ready[tag_id[LAT-1]] low.
REQ-019 A tag pipeline of LAT stages (tag_v, tag_id) SHALL advance only when ce is high.
REQ-020 Stage 0 of the tag pipeline SHALL load the accept flag and the granted index.
REQ-021 req_ready SHALL be all-zero while stall is high. Otherwise req_ready SHALL be the grant vector, which is zero if no req_valid is high.
REQ-022 rsp_valid[k] SHALL be high iff tag_v[LAT-1] is high and tag_id[LAT-1] equals k.
REQ-023 rsp_p SHALL be the multiplier output.
REQ-024 rsp_valid and rsp_p SHALL hold stable while stall is high.
REQ-025 Latency: an accept in cycle t with no stalls SHALL produce rsp_valid in cycle t+3. Each stall cycle SHALL add one cycle.
REQ-026 Throughput SHALL be one accept per cycle with no stalls. A result completing and a new accept in the same cycle SHALL both proceed.
REQ-027 Arithmetic: product = signed a × zero-extended b, exact in 25 bits, with no saturation or rounding.
REQ-028 Results SHALL return in acceptance order. No reordering is permitted.
REQ-029 Bubbles (cycles with no accept) SHALL occupy pipeline slots with tag_v=0 and SHALL never raise rsp_valid.
REQ-030 busy SHALL equal the OR of all tag_v bits.
REQ-031 A requester withdrawing req_valid before acceptance SHALL be legal. The arbiter SHALL re-evaluate every cycle.

Reset
REQ-032 While reset is high, the block SHALL clear tag_v to 0, set tag_id to 0, and set last_grant to NREQ-1, so requester 0 wins first.
REQ-033 While reset is high, req_ready, rsp_valid and busy SHALL be 0 from the cycle after reset is sampled.
REQ-034 Multiplier data registers SHALL NOT be reset. Their stale contents SHALL be masked by tag_v.
REQ-035 Reset mid-operation SHALL silently drop all in-flight operations, with no rsp_valid for any of them.
REQ-036 The first accept SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-037 A shared package SHALL hold the following:
- widths A_W=16, B_W=8, P_W=25;
- constant LAT=3;
- the requester-index typedef, sized by clog2 of the maximum NREQ.
REQ-038 The block SHALL instantiate exactly one sub-module: the existing TOP_mul_mul_16s_8ns_25_4_1 with ID=1, NUM_STAGE=4, din0_WIDTH=16, din1_WIDTH=8, dout_WIDTH=25.
REQ-039 The instance SHALL have its reset tied to reset and its ce tied to the internal ce.
REQ-040 Arbiter, mux and tag pipeline SHALL be inline logic. No other sub-modules are permitted.

Verification
REQ-041 Single op: after reset, req0 presents a=-3, b=200 for one cycle -> req_ready[0]=1 that cycle, then rsp_valid[0]=1 with rsp_p=-600 exactly 3 cycles later, and busy=1 for those 3 cycles.
REQ-042 Extremes: a=32767, b=255 -> 8355585; a=-32768, b=255 -> -8355840; a=-1, b=0 -> 0; all with correct 25-bit sign.
REQ-043 Contention: req0 and req1 both valid continuously for 6 cycles with distinct operands -> grants alternate 0,1,0,1,0,1; responses arrive in the same order on the matching rsp_valid bits, one per cycle.
REQ-044 Backpressure: 3 back-to-back ops from req1, with rsp_ready[1] low for 4 cycles when the first result appears -> rsp_valid[1] and rsp_p held for 4 cycles, req_ready=0 throughout, then 3 results delivered in order with no loss or duplication.
REQ-045 Reset mid-flight: 2 ops accepted, reset asserted 1 cycle later for 1 cycle -> no rsp_valid ever for those ops, busy=0 after reset, and the next req1 request is granted in the first cycle after reset.
REQ-046 Random soak: 10,000 cycles with random req_valid/rsp_ready and operands -> a scoreboard confirms every accepted op returns exactly once, in order, with the correct product, and that no requester is ever starved for more than NREQ-1 grants.

Source files
------------

// File: rtl/mul_share_sched_pkg.sv
// mul_share_sched_pkg: shared widths, pipeline latency and requester index type
package mul_share_sched_pkg;
   localparam int A_W = 16;
   localparam int B_W = 8;
   localparam int P_W = 25;
   localparam int LAT = 3;
   localparam int MAX_NREQ = 4;
   typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;
endpackage

// File: rtl/mul_share_sched_if.sv
// mul_share_sched_if: per-requester operand/result handshakes plus the shared product bus
interface mul_share_sched_if #(parameter int NREQ = 2);
   import mul_share_sched_pkg::*;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*A_W-1:0] req_a;
   logic [NREQ*B_W-1:0] req_b;
   logic [NREQ-1:0] rsp_valid;
   logic [NREQ-1:0] rsp_ready;
   logic signed [P_W-1:0] rsp_p;
   logic busy;
   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_p, busy
   );
   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_p, busy
   );
endinterface

// File: rtl/mul_share_sched_mul.sv
// TOP_mul_mul_16s_8ns_25_4_1: signed x unsigned multiplier, NUM_STAGE-1 register stages gated by ce
module TOP_mul_mul_16s_8ns_25_4_1 #(
   parameter int ID = 1,
   parameter int NUM_STAGE = 4,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 25
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout
);
   logic signed [din0_WIDTH-1:0] r_a;
   logic [din1_WIDTH-1:0] r_b;
   logic signed [dout_WIDTH-1:0] r_p [NUM_STAGE-2];
   logic signed [dout_WIDTH-1:0] w_a;
   logic signed [dout_WIDTH-1:0] w_b;
   logic w_unused;
   assign w_a = dout_WIDTH'(r_a);
   assign w_b = dout_WIDTH'({1'b0, r_b});
   assign dout = r_p[NUM_STAGE-3];
   assign w_unused = reset | (ID < 0);
   // data path carries no reset; stale contents are qualified by the caller's tags
   always_ff @(posedge clk) begin
      if (ce) begin
         r_a <= din0;
         r_b <= din1;
         r_p[0] <= w_a * w_b;
         for (int i = 1; i < NUM_STAGE - 2; i++) r_p[i] <= r_p[i-1];
      end
   end
endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin sharing of one pipelined multiplier among NREQ requesters
module mul_share_sched #(
   parameter int NREQ = 2,
   parameter int LAT = 3
) (
   input logic clk,
   input logic reset,
   mul_share_sched_if.slave bus
);
   import mul_share_sched_pkg::*;
   logic w_stall;
   logic w_ce;
   logic w_acc;
   logic w_gnt_any;
   logic [NREQ-1:0] w_gnt;
   logic [NREQ-1:0] w_rsp_v;
   req_idx_t w_gnt_id;
   req_idx_t r_last;
   logic [LAT-1:0] r_tag_v;
   req_idx_t r_tag_id [LAT];
   logic [A_W-1:0] w_a;
   logic [B_W-1:0] w_b;
   logic signed [P_W-1:0] w_p;
   assign w_rsp_v = r_tag_v[LAT-1] ? (NREQ'(1) << r_tag_id[LAT-1]) : '0;
   assign w_stall = |(w_rsp_v & ~bus.rsp_ready);
   assign w_ce = ~w_stall;
   assign w_gnt = (w_gnt_any & ~w_stall & ~reset) ? (NREQ'(1) << w_gnt_id) : '0;
   assign w_acc = |w_gnt;
   assign w_a = A_W'(bus.req_a >> (int'(w_gnt_id) * A_W));
   assign w_b = B_W'(bus.req_b >> (int'(w_gnt_id) * B_W));
   assign bus.req_ready = w_gnt;
   assign bus.rsp_valid = w_rsp_v;
   assign bus.rsp_p = w_p;
   assign bus.busy = |r_tag_v;
   // round-robin pick: the nearest valid requester after the last grant wins
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (|(bus.req_valid & (NREQ'(1) << ((int'(r_last) + k) % NREQ)))) begin
            w_gnt_any = 1'b1;
            w_gnt_id = req_idx_t'((int'(r_last) + k) % NREQ);
         end
      end
   end
   // tag pipeline shadows the multiplier stages; the pointer moves only on an accept
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_v <= '0;
         for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
         r_last <= req_idx_t'(NREQ - 1);
      end else begin
         if (w_ce) begin
            r_tag_v <= {r_tag_v[LAT-2:0], w_acc};
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
         end
         if (w_acc) r_last <= w_gnt_id;
      end
   end
   TOP_mul_mul_16s_8ns_25_4_1 #(
      .ID(1),
      .NUM_STAGE(4),
      .din0_WIDTH(A_W),
      .din1_WIDTH(B_W),
      .dout_WIDTH(P_W)
   ) u_mul (
      .clk(clk),
      .reset(reset),
      .ce(w_ce),
      .din0(w_a),
      .din1(w_b),
      .dout(w_p)
   );
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: directed vectors, multi-cycle corner sequences and a scoreboarded random soak
module tb_mul_share_sched;
   import mul_share_sched_pkg::*;
   localparam int N = 2;
   typedef struct { int id; int a; int b; int p; } vec_t;
   typedef struct { int id; int p; } exp_t;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int failures = 0;
   exp_t sb [$];
   int wait_cnt [N];
   logic [N-1:0] prev_v;
   logic signed [P_W-1:0] prev_p;
   always #5 clk = ~clk;
   mul_share_sched_if #(.NREQ(N)) bus ();
   mul_share_sched #(.NREQ(N), .LAT(3)) dut (.clk(clk), .reset(reset), .bus(bus));
   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask
   task automatic next();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.req_valid = '0;
      bus.rsp_ready = '1;
   endtask
   task automatic put(input int id, input int a, input int b);
      bus.req_valid[id] = 1'b1;
      bus.req_a[id*A_W +: A_W] = A_W'(a);
      bus.req_b[id*B_W +: B_W] = B_W'(b);
   endtask
   task automatic single(input vec_t v);
      put(v.id, v.a, v.b);
      @(negedge clk);
      chk("op_ready", bus.req_ready, 1 << v.id);
      chk("op_busy_pre", bus.busy, 0);
      next();
      idle();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("op_busy", bus.busy, 1);
         chk("op_valid", bus.rsp_valid, c == 3 ? 1 << v.id : 0);
         if (c == 3) chk("op_p", bus.rsp_p, v.p);
         next();
      end
   endtask
   task automatic observe();
      exp_t e;
      @(negedge clk);
      if (prev_v != '0) begin
         chk("hold_valid", bus.rsp_valid, prev_v);
         chk("hold_p", bus.rsp_p, prev_p);
      end
      if (bus.rsp_valid != '0) begin
         if (sb.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
         else begin
            e = sb[0];
            chk("rsp_id", bus.rsp_valid, 1 << e.id);
            chk("rsp_p", bus.rsp_p, e.p);
            if (|(bus.rsp_valid & bus.rsp_ready)) void'(sb.pop_front());
         end
      end
      if (bus.req_ready != '0) begin
         chk("grant_legal", $onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0), 1);
         for (int i = 0; i < N; i++)
            if (bus.req_ready[i])
               sb.push_back('{i, int'(signed'(bus.req_a[i*A_W +: A_W])) * int'(bus.req_b[i*B_W +: B_W])});
      end
      for (int i = 0; i < N; i++) begin
         if (bus.req_valid[i] && !bus.req_ready[i] && bus.req_ready != '0) begin
            wait_cnt[i]++;
            chk("no_starve", wait_cnt[i] <= N - 1, 1);
         end else if (bus.req_ready[i] || !bus.req_valid[i]) wait_cnt[i] = 0;
      end
      prev_v = ((bus.rsp_valid & ~bus.rsp_ready) != '0) ? bus.rsp_valid : '0;
      prev_p = bus.rsp_p;
   endtask
   initial begin
      vec_t vt [6];
      int ep [6];
      int bpa [3];
      int bpb [3];
      int bpp [3];
      vt[0] = '{0, -3, 200, -600};
      vt[1] = '{1, 32767, 255, 8355585};
      vt[2] = '{0, -32768, 255, -8355840};
      vt[3] = '{1, -1, 0, 0};
      vt[4] = '{0, 123, 45, 5535};
      vt[5] = '{1, -1000, 7, -7000};
      bpa = '{-5, 2000, -32768};
      bpb = '{9, 100, 1};
      bpp = '{-45, 200000, -32768};
      reset = 1'b1;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_valid = '1;
      bus.rsp_ready = '1;
      next();
      next();
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      next();
      reset = 1'b0;
      idle();
      for (int i = 0; i < 6; i++) single(vt[i]);
      for (int c = 0; c < 10; c++) begin
         if (c < 6) begin
            put(0, 10*c + 1, c + 2);
            put(1, -(10*c + 3), c + 5);
            ep[c] = (c % 2 == 0) ? (10*c + 1) * (c + 2) : -(10*c + 3) * (c + 5);
         end else idle();
         @(negedge clk);
         if (c < 6) chk("cont_grant", bus.req_ready, 1 << (c % 2));
         chk("cont_valid", bus.rsp_valid, (c >= 3 && c < 9) ? 1 << ((c - 3) % 2) : 0);
         if (c >= 3 && c < 9) chk("cont_p", bus.rsp_p, ep[c-3]);
         next();
      end
      for (int c = 0; c < 11; c++) begin
         idle();
         if (c < 3) put(1, bpa[c], bpb[c]);
         if (c >= 3 && c <= 6) begin
            bus.req_valid = '1;
            bus.rsp_ready = 2'b01;
         end
         @(negedge clk);
         if (c < 3) chk("bp_accept", bus.req_ready, 2);
         if (c >= 3 && c <= 6) chk("bp_ready_low", bus.req_ready, 0);
         chk("bp_valid", bus.rsp_valid, (c >= 3 && c <= 9) ? 2 : 0);
         if (c >= 3 && c <= 9) chk("bp_p", bus.rsp_p, bpp[c <= 7 ? 0 : c - 7]);
         next();
      end
      for (int c = 0; c < 8; c++) begin
         idle();
         reset = (c == 2);
         if (c == 0) put(0, 77, 3);
         if (c == 1) put(1, 5, 6);
         if (c == 3) put(1, -7, 11);
         @(negedge clk);
         if (c < 2) chk("rm_accept", bus.req_ready, 1 << c);
         if (c == 3) begin
            chk("rm_busy", bus.busy, 0);
            chk("rm_regrant", bus.req_ready, 2);
         end
         chk("rm_valid", bus.rsp_valid, c == 6 ? 2 : 0);
         if (c == 6) chk("rm_p", bus.rsp_p, -77);
         next();
      end
      reset = 1'b0;
      prev_v = '0;
      prev_p = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
         for (int i = 0; i < N; i++) bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
         bus.req_a = (N*A_W)'($urandom);
         bus.req_b = (N*B_W)'($urandom);
         observe();
         next();
      end
      idle();
      for (int c = 0; c < 8; c++) begin
         observe();
         next();
      end
      chk("soak_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
